// File: rtl/serial_sub_4bit_pkg.sv
// Shared arithmetic definitions for the bit-serial subtractor: default
// operand width, controller state encoding and the counter sizing helper.
package serial_sub_4bit_pkg;

    localparam int SUB_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Bit counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_4bit_if.sv
// Start/busy/done request bundle between a controller (master) and the
// serial subtractor (slave).
interface serial_sub_4bit_if
    import serial_sub_4bit_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf
    );

endinterface

// File: rtl/serial_sub_4bit_full_sub_1bit.sv
// Single full-subtractor cell: x - y - bin, producing a difference bit and
// a borrow out. Purely combinational; the top reuses it once per bit.
module full_sub_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow of one bit position.
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_sub_4bit.sv
// Bit-serial two's-complement subtractor. Operands are latched on an
// accepted start, then shifted LSB-first through one full-subtractor cell
// with a registered borrow. Results are published only when DONE is entered
// and are held until the next completed operation.
module serial_sub_4bit
    import serial_sub_4bit_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    serial_sub_4bit_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_t       state;
    sub_state_t       state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             busy_nxt;
    logic             done_nxt;
    logic             accept;
    logic             last_bit;

    logic             cell_d;
    logic             cell_b;
    logic [WIDTH-1:0] result_word;

    full_sub_1bit u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_b)
    );

    // The difference register after this cycle's bit enters at the MSB;
    // on the last bit this is the complete result.
    assign result_word = {cell_d, sd[WIDTH-1:1]};

    // State register plus registered busy/done so every output comes from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state decode; busy_nxt/done_nxt describe the state being entered.
    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                busy_nxt = 1'b1;
                if (cnt == CNT_LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (accept) begin
            sa    <= bus.a;
            sb    <= bus.b;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (state == RUN) begin
            sa    <= {1'b0, sa[WIDTH-1:1]};
            sb    <= {1'b0, sb[WIDTH-1:1]};
            sd    <= result_word;
            br    <= cell_b;
            cnt   <= cnt + 1'b1;
        end
    end

    // Result registers, loaded only on the transition into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_bit) begin
            diff_q <= result_word;
            bout_q <= cell_b;
            ovf_q  <= (a_msb != b_msb) && (cell_d != a_msb);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;

endmodule
